// File: rtl/bus_pkg.sv
// Shared bus-bench package: id constants, scenario/transaction enums and packet builder.
package bus_pkg;

   localparam int unsigned ANCHO_ID = 8;
   localparam logic [ANCHO_ID-1:0] ID_BROADCAST = 8'hFF;
   localparam int unsigned TAMA_PAQUETE = 32;

   typedef enum logic [2:0] {
      todos_a_todos,
      todos_a_uno,
      uno_a_todos,
      uno_a_uno,
      broadcast_puro,
      reset_medio
   } cas_esq;

   typedef enum logic [1:0] {
      trans_aleatoria,
      trans_especifica,
      trans_broadcast,
      trans_reset
   } tipos_de_transaccion;

   // Destination id goes in the top byte, payload below it.
   function automatic logic [TAMA_PAQUETE-1:0] armar_paquete(
      input logic [ANCHO_ID-1:0] id,
      input logic [TAMA_PAQUETE-ANCHO_ID-1:0] payload
   );
      return {id, payload};
   endfunction

endpackage

// File: rtl/fifo_entrada_bus_if.sv
// Driver-side and bus-side signals of one per-device input FIFO.
// With FIFO_ESTADISTICAS_EN defined, the push/drop statistic counters are carried too.
interface fifo_entrada_bus_if #(
   parameter int unsigned tama_de_paquete = 32,
   parameter int unsigned profundidad = 8
);
   localparam int unsigned ANCHO_CUENTA = $clog2(profundidad) + 1;

   logic                       push_drv;
   logic [tama_de_paquete-1:0] dato_drv;
   logic                       full;
   logic                       pop;
   logic                       pndng;
   logic [tama_de_paquete-1:0] D_pop;
   logic [ANCHO_CUENTA-1:0]    cuenta;
   logic                       overflow;
`ifdef FIFO_ESTADISTICAS_EN
   logic [31:0]                total_push;
   logic [15:0]                total_drop;

   modport master (
      output push_drv, dato_drv, pop,
      input  full, pndng, D_pop, cuenta, overflow, total_push, total_drop
   );
   modport slave (
      input  push_drv, dato_drv, pop,
      output full, pndng, D_pop, cuenta, overflow, total_push, total_drop
   );
`else
   modport master (
      output push_drv, dato_drv, pop,
      input  full, pndng, D_pop, cuenta, overflow
   );
   modport slave (
      input  push_drv, dato_drv, pop,
      output full, pndng, D_pop, cuenta, overflow
   );
`endif

endinterface

// File: rtl/fifo_mem_dp.sv
// Register array with one synchronous write port and one asynchronous read port.
module fifo_mem_dp #(
   parameter int unsigned ancho = 32,
   parameter int unsigned profundidad = 8
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(profundidad)-1:0] waddr,
   input  logic [ancho-1:0]               wdata,
   input  logic [$clog2(profundidad)-1:0] raddr,
   output logic [ancho-1:0]               rdata
);

   logic [ancho-1:0] mem [profundidad];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_entrada_bus.sv
// Per-device show-ahead input FIFO between the test driver and one bus port.
// Optional FIFO_ESTADISTICAS_EN adds saturating push/drop counters.
module fifo_entrada_bus
   import bus_pkg::*;
#(
   parameter int unsigned tama_de_paquete = TAMA_PAQUETE,
   parameter int unsigned profundidad = 8
) (
   input logic               clk,
   input logic               reset,
   fifo_entrada_bus_if.slave bus
);

   localparam int unsigned ANCHO_PTR = $clog2(profundidad);
   localparam int unsigned ANCHO_CUENTA = ANCHO_PTR + 1;
   localparam logic [ANCHO_CUENTA-1:0] CUENTA_LLENA = ANCHO_CUENTA'(profundidad);

   logic [ANCHO_PTR-1:0]       rd_ptr_q, wr_ptr_q;
   logic [ANCHO_CUENTA-1:0]    cuenta_q, cuenta_d;
   logic                       overflow_q;
   logic [tama_de_paquete-1:0] dato_cabeza;
   logic                       pndng, full;
   logic                       pop_ef, push_ef, descarte;

   assign pndng = (cuenta_q != '0);
   assign full  = (cuenta_q == CUENTA_LLENA);

   // A push into a full FIFO still lands if the head is retired in the same cycle.
   always_comb begin
      pop_ef   = bus.pop & pndng;
      push_ef  = bus.push_drv & (~full | pop_ef);
      descarte = bus.push_drv & ~push_ef;
      cuenta_d = cuenta_q;
      if (push_ef && !pop_ef) begin
         cuenta_d = cuenta_q + ANCHO_CUENTA'(1);
      end else if (pop_ef && !push_ef) begin
         cuenta_d = cuenta_q - ANCHO_CUENTA'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cuenta_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pop_ef) begin
            rd_ptr_q <= rd_ptr_q + ANCHO_PTR'(1);
         end
         if (push_ef) begin
            wr_ptr_q <= wr_ptr_q + ANCHO_PTR'(1);
         end
         cuenta_q   <= cuenta_d;
         overflow_q <= descarte;
      end
   end

   fifo_mem_dp #(
      .ancho       (tama_de_paquete),
      .profundidad (profundidad)
   ) u_mem (
      .clk   (clk),
      .we    (push_ef & ~reset),
      .waddr (wr_ptr_q),
      .wdata (bus.dato_drv),
      .raddr (rd_ptr_q),
      .rdata (dato_cabeza)
   );

   assign bus.pndng    = pndng;
   assign bus.full     = full;
   assign bus.cuenta   = cuenta_q;
   assign bus.overflow = overflow_q;
   assign bus.D_pop    = pndng ? dato_cabeza : '0;

`ifdef FIFO_ESTADISTICAS_EN
   logic [31:0] total_push_q;
   logic [15:0] total_drop_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         total_push_q <= '0;
         total_drop_q <= '0;
      end else begin
         if (push_ef && (total_push_q != '1)) begin
            total_push_q <= total_push_q + 32'd1;
         end
         if (descarte && (total_drop_q != '1)) begin
            total_drop_q <= total_drop_q + 16'd1;
         end
      end
   end

   assign bus.total_push = total_push_q;
   assign bus.total_drop = total_drop_q;
`endif

endmodule

// File: tb/tb_fifo_entrada_bus.sv
// Scoreboard bench for fifo_entrada_bus: directed scenarios plus random push/pop traffic
// checked against a queue-based reference model.
module tb_fifo_entrada_bus;
   import bus_pkg::*;

   localparam int unsigned PROF = 8;

   typedef struct {
      logic [31:0] cuenta;
      logic        pndng;
      logic        full;
      logic        overflow;
      logic [31:0] d_pop;
      logic [31:0] tp;
      logic [15:0] td;
   } estado_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   fifo_entrada_bus_if #(.tama_de_paquete(32), .profundidad(PROF)) bus_if ();

   fifo_entrada_bus #(
      .tama_de_paquete (32),
      .profundidad     (PROF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelo[$];
   logic [31:0] esp_datos[$];
   estado_t     esp_estado[$];
   logic [31:0] m_tp = 0;
   logic [15:0] m_td = 0;

   task automatic comparar(input string nombre, input logic [31:0] obtenido,
                           input logic [31:0] esperado);
      checks++;
      if (obtenido !== esperado) begin
         errors++;
         $display("FAIL %s: obtenido=%h esperado=%h (t=%0t)", nombre, obtenido, esperado, $time);
      end
   endtask

   // One clock of stimulus; the model advances by the specification's push/pop rules.
   task automatic ciclo(input bit ps, input logic [31:0] d, input bit pp, input bit rst);
      estado_t e;
      bit pe, we, ov;
      @(posedge clk);
      #1;
      reset           = rst;
      bus_if.push_drv = ps;
      bus_if.dato_drv = d;
      bus_if.pop      = pp;
      ov = 1'b0;
      if (rst) begin
         modelo.delete();
         m_tp = 0;
         m_td = 0;
      end else begin
         pe = pp && (modelo.size() > 0);
         we = ps && ((modelo.size() < PROF) || pe);
         ov = ps && !we;
         if (pe) esp_datos.push_back(modelo.pop_front());
         if (we) modelo.push_back(d);
         if (we && m_tp != 32'hFFFF_FFFF) m_tp++;
         if (ov && m_td != 16'hFFFF) m_td++;
      end
      e.cuenta   = modelo.size();
      e.pndng    = modelo.size() != 0;
      e.full     = modelo.size() == PROF;
      e.overflow = ov;
      e.d_pop    = (modelo.size() != 0) ? modelo[0] : 32'h0;
      e.tp       = m_tp;
      e.td       = m_td;
      esp_estado.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) ciclo(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic hacer_reset();
      ciclo(1'b0, 32'h0, 1'b0, 1'b1);
      ciclo(1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   // Monitor: pops the data scoreboard on every accepted pop, and checks the
   // registered state one cycle behind the stimulus that produced it.
   initial begin
      estado_t e;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (!reset && bus_if.pop === 1'b1 && bus_if.pndng === 1'b1) begin
            if (esp_datos.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dato_pop: obtenido=%h esperado=ninguno (t=%0t)", bus_if.D_pop, $time);
            end else begin
               d = esp_datos.pop_front();
               comparar("dato_pop", bus_if.D_pop, d);
            end
         end
         if (esp_estado.size() >= 2) begin
            e = esp_estado.pop_front();
            comparar("cuenta", 32'(bus_if.cuenta), e.cuenta);
            comparar("pndng", 32'(bus_if.pndng), 32'(e.pndng));
            comparar("full", 32'(bus_if.full), 32'(e.full));
            comparar("overflow", 32'(bus_if.overflow), 32'(e.overflow));
            comparar("D_pop", bus_if.D_pop, e.d_pop);
`ifdef FIFO_ESTADISTICAS_EN
            comparar("total_push", bus_if.total_push, e.tp);
            comparar("total_drop", 32'(bus_if.total_drop), 32'(e.td));
`endif
         end
      end
   end

   initial begin
      bus_if.push_drv = 1'b0;
      bus_if.dato_drv = '0;
      bus_if.pop      = 1'b0;

      // Three pushes, no pop.
      hacer_reset();
      ciclo(1'b1, 32'hAA00_0001, 1'b0, 1'b0);
      ciclo(1'b1, 32'h0500_0002, 1'b0, 1'b0);
      ciclo(1'b1, 32'hFF00_0003, 1'b0, 1'b0);
      idle(2);

      // Fill, overflow, drain.
      hacer_reset();
      for (int i = 0; i < PROF; i++) ciclo(1'b1, armar_paquete(8'(i + 1), 24'(i * 16 + 7)), 1'b0, 1'b0);
      ciclo(1'b1, 32'h1234_5678, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < PROF; i++) ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      idle(1);

      // Full with simultaneous push and pop.
      for (int i = 0; i < PROF; i++) ciclo(1'b1, armar_paquete(ID_BROADCAST, 24'(i)), 1'b0, 1'b0);
      ciclo(1'b1, 32'h0F0F_0F0F, 1'b1, 1'b0);
      idle(1);
      for (int i = 0; i < PROF; i++) ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      idle(1);

      // Push+pop on empty, then pops on empty.
      ciclo(1'b1, 32'h0100_0009, 1'b1, 1'b0);
      idle(1);
      ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      idle(1);

      // Pointer wrap.
      for (int i = 0; i < 5; i++) ciclo(1'b1, armar_paquete(8'h30, 24'(i)), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) ciclo(1'b1, armar_paquete(8'h31, 24'(i)), 1'b0, 1'b0);
      for (int i = 0; i < PROF; i++) ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      idle(1);

      // Reset with a concurrent push discards everything.
      for (int i = 0; i < 4; i++) ciclo(1'b1, armar_paquete(8'h40, 24'(i)), 1'b0, 1'b0);
      ciclo(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
      idle(2);

      // Random traffic with rare resets.
      for (int i = 0; i < 600; i++) begin
         ciclo($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
               $urandom_range(0, 199) == 0);
      end
      for (int i = 0; i < PROF + 1; i++) ciclo(1'b0, 32'h0, 1'b1, 1'b0);
      idle(2);
      @(negedge clk);
      #1;
      comparar("datos_pendientes", 32'(esp_datos.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_entrada_bus.md
Name: fifo_entrada_bus

Overview:
- Per-device input FIFO between the test driver and one bus port of the bus DUT.
- Driver side: the driver pushes packets.
- Bus side: the block presents `pndng`/`D_pop` to the bus and retires the head entry on `pop`.
- The bench instantiates one per [bus][controller] slot; its bus-side signals map 1:1 onto `pndng`/`pop`/`D_pop` of the DUT interface.

Parameters:
- `tama_de_paquete`, 32, packet width in bits; upper 8 bits are destination id, rest is payload.
- `profundidad`, 8, number of entries; power of two, >= 2.

Ports:
- `clk`, input, 1, single clock; all logic on rising edge.
- `reset`, input, 1, synchronous, active-high; clears all state.
- `push_drv`, input, 1, driver write request.
- `dato_drv`, input, `tama_de_paquete`, packet from driver.
- `full`, output, 1, FIFO holds `profundidad` entries.
- `pop`, input, 1, bus consumes head entry.
- `pndng`, output, 1, FIFO non-empty.
- `D_pop`, output, `tama_de_paquete`, head entry (show-ahead).
- `cuenta`, output, `$clog2(profundidad)+1`, current occupancy.
- `overflow`, output, 1, one-cycle pulse: a push was dropped.

Behaviour:
- **Reset** (sampled on `clk` while `reset`=1): read/write pointers=0, `cuenta`=0, `pndng`=0, `full`=0, `overflow`=0, `D_pop`=0. Memory contents need not clear. Reset has priority over any simultaneous push/pop; in-flight data is discarded.
- **Storage:** circular buffer, pointers of width `$clog2(profundidad)`, wrap modulo `profundidad`. `cuenta` tracks occupancy.
- **Outputs:** `pndng` = (`cuenta`!=0); `full` = (`cuenta`==`profundidad`); both derived from registered `cuenta`.
- **Show-ahead:** `D_pop` = mem[rd_ptr] when `pndng`=1, else 0.
- **Latency:** a push accepted in cycle N is visible on `D_pop` / `pndng` in cycle N+1. A pop in cycle N presents the next entry in N+1.
- **Pop:**
  - Effective only when `pndng`=1: advances rd_ptr, `cuenta`-1.
  - Pop on empty is ignored; no state change, no error flag.
- **Push:**
  - Effective when `full`=0, or when `full`=1 and an effective pop occurs in the same cycle.
  - Writes mem[wr_ptr], advances wr_ptr, `cuenta`+1.
- **Simultaneous push+pop:**
  - Non-empty, non-full: both effective, `cuenta` unchanged.
  - Full: both effective, `cuenta` stays `profundidad`, no overflow.
  - Empty: push effective, pop ignored, `cuenta`→1.
- **Overflow:** push while full without a same-cycle effective pop drops the packet. `overflow`=1 for exactly the next cycle; FIFO contents unchanged.
- **Ordering:** strict FIFO; no reordering, no content inspection (the destination id is passed through untouched).

Optional Feature:
- Macro: `FIFO_ESTADISTICAS_EN`.
- **Defined:** adds outputs `total_push` (32b) and `total_drop` (16b).
  - `total_push` counts effective pushes; `total_drop` counts dropped pushes.
  - Both saturate at all-ones, clear on `reset`, and update one cycle after the event.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `bus_pkg`:
  - `localparam ANCHO_ID=8`.
  - `localparam ID_BROADCAST=8'hFF`.
  - The `cas_esq` and `tipos_de_transaccion` enums.
  - Helper function `armar_paquete(id, payload)`, used by bench and scoreboard.
- One natural sub-module: `fifo_mem_dp`, a simple dual-port register array with one write port and asynchronous read addressed by rd_ptr. The pointer/count control stays in the top.

Test Plan:
- Reset, then push 0xAA000001, 0x05000002, 0xFF000003 on consecutive cycles, no pop → `cuenta`=3, `pndng`=1, `D_pop`=0xAA000001 from the cycle after the first push.
- Fill 8 entries, push 0x12345678 with `pop`=0 → `full`=1, `overflow` pulses one cycle, `cuenta`=8. Later pops return the original 8 packets in order; 0x12345678 never appears.
- With FIFO full, assert push(0x0F0F0F0F) and pop in the same cycle → `cuenta` stays 8, no overflow, 0x0F0F0F0F emerges as the 8th pop.
- Empty FIFO, push 0x01000009 and pop together → `cuenta`=1, `D_pop`=0x01000009 next cycle. Pop on empty otherwise leaves `cuenta`=0, `D_pop`=0.
- Push 5 entries, pop 3, push 6 more (pointer wrap) → 8 entries drained in exact push order, `pndng`=0 after the last pop.
- Load 4 entries, assert `reset` for 1 cycle with a concurrent push → next cycle `cuenta`=0, `pndng`=0, `D_pop`=0, `full`=0. With `FIFO_ESTADISTICAS_EN`, counters also read 0.
